// File: rtl/operand_issue_pkg.sv
// rtl/operand_issue_pkg.sv - shared constants and issue-entry type for operand_issue
package operand_issue_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;

  // One queued issue: both operands plus the add/sub select taken from A
  typedef struct packed {
    logic [DEF_WIDTH-1:0] opa;
    logic [DEF_WIDTH-1:0] opb;
    logic                 sel;
  } issue_entry_t;

  // Occupancy counter needs one extra bit to represent "full"
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// rtl/issue_fifo.sv - parameterised synchronous FIFO with push/pop/count
module issue_fifo
  import operand_issue_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_WIDTH + 1,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          pop,
  output logic [WIDTH-1:0]              rdata,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array: written on push only, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Empty FIFO reads as zero so uninitialised storage never reaches the outputs
  always_comb begin
    rdata = '0;
    if (count != '0) begin
      rdata = mem[rd_ptr];
    end
  end

  assign full = (count == DEPTH_C);

endmodule

// File: rtl/operand_issue.sv
// rtl/operand_issue.sv - pairs A/B operands in order and queues them for the add/sub stage
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_valid,
  input  logic [WIDTH-1:0]          a_data,
  input  logic                      a_sel,
  output logic                      a_ready,
  input  logic                      b_valid,
  input  logic [WIDTH-1:0]          b_data,
  output logic                      b_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          opa,
  output logic [WIDTH-1:0]          opb,
  output logic                      sel,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int EW = 2 * WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             sel;
  } entry_t;

  logic [WIDTH-1:0] a_slot;
  logic             a_sel_slot;
  logic             a_full;
  logic [WIDTH-1:0] b_slot;
  logic             b_full;

  logic   push;
  logic   pop;
  logic   fifo_full;
  logic   a_take;
  logic   b_take;
  entry_t wr_entry;
  entry_t rd_entry;

  // A pair moves into the FIFO once both slots hold data and there is room
  // (or a slot is being freed by an issue on the same edge)
  assign pop     = out_valid && out_ready;
  assign push    = a_full && b_full && (!fifo_full || pop);
  assign a_ready = !a_full || push;
  assign b_ready = !b_full || push;
  assign a_take  = a_valid && a_ready;
  assign b_take  = b_valid && b_ready;

  assign wr_entry = '{opa: a_slot, opb: b_slot, sel: a_sel_slot};

  // A slot: reload wins over the clear that a push would otherwise do
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_full <= 1'b0;
    end else if (a_take) begin
      a_full <= 1'b1;
    end else if (push) begin
      a_full <= 1'b0;
    end
  end

  // A slot data: captured on acceptance only, no reset needed
  always_ff @(posedge clk) begin
    if (a_take) begin
      a_slot     <= a_data;
      a_sel_slot <= a_sel;
    end
  end

  // B slot: same reload-over-clear priority as A
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_full <= 1'b0;
    end else if (b_take) begin
      b_full <= 1'b1;
    end else if (push) begin
      b_full <= 1'b0;
    end
  end

  // B slot data: captured on acceptance only, no reset needed
  always_ff @(posedge clk) begin
    if (b_take) begin
      b_slot <= b_data;
    end
  end

  issue_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .count (count),
    .full  (fifo_full)
  );

  assign out_valid = (count != '0);
  assign opa       = rd_entry.opa;
  assign opb       = rd_entry.opb;
  assign sel       = rd_entry.sel;

endmodule

// File: tb/tb_operand_issue.sv
// tb/tb_operand_issue.sv - scoreboard bench for operand_issue
module tb_operand_issue;
  import operand_issue_pkg::*;

  localparam int W     = DEF_WIDTH;
  localparam int D     = DEF_DEPTH;
  localparam int NPAIR = 10000;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid;
  logic [W-1:0] a_data;
  logic         a_sel;
  logic         a_ready;
  logic         b_valid;
  logic [W-1:0] b_data;
  logic         b_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         sel;
  logic [2:0]   count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_recv   = 0;

  logic [W:0]   a_q [$];
  logic [W-1:0] b_q [$];
  issue_entry_t exp_q [$];

  operand_issue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_sel     (a_sel),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opa       (opa),
    .opb       (opb),
    .sel       (sel),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with inputs set: predicts transfers, checks the
  // head of the FIFO against the model, advances one clock, drops accepted valids
  task automatic tick();
    logic a_fire;
    logic b_fire;
    logic o_fire;
    logic [W:0] a_ent;
    issue_entry_t e;
    #1;
    a_fire = a_valid && a_ready;
    b_fire = b_valid && b_ready;
    o_fire = out_valid && out_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("issue_without_pair", 64'(out_valid), 64'(0));
      end else begin
        check("head_opa", 64'(opa), 64'(exp_q[0].opa));
        check("head_opb", 64'(opb), 64'(exp_q[0].opb));
        check("head_sel", 64'(sel), 64'(exp_q[0].sel));
      end
    end
    if (o_fire && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      n_recv++;
    end
    if (a_fire) a_q.push_back({a_sel, a_data});
    if (b_fire) b_q.push_back(b_data);
    while (a_q.size() != 0 && b_q.size() != 0) begin
      a_ent = a_q.pop_front();
      e.opa = a_ent[W-1:0];
      e.sel = a_ent[W];
      e.opb = b_q.pop_front();
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (a_fire) a_valid = 1'b0;
    if (b_fire) b_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [W-1:0] a, input logic s, input logic [W-1:0] b);
    int n;
    a_valid = 1'b1; a_data = a; a_sel = s;
    b_valid = 1'b1; b_data = b;
    n = 0;
    while ((a_valid || b_valid) && n < 50) begin
      tick();
      n++;
    end
    check("send_pair_accepted", 64'(a_valid || b_valid), 64'(0));
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0; a_sel = 1'b0;
    b_valid = 1'b0; b_data = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_a_ready", 64'(a_ready), 64'(1));
    check("rst_b_ready", 64'(b_ready), 64'(1));
    check("rst_opa", 64'(opa), 64'(0));
    check("rst_opb", 64'(opb), 64'(0));
    check("rst_sel", 64'(sel), 64'(0));
    @(negedge clk);

    // Single pair, both operands on the same edge
    out_ready = 1'b1;
    a_valid = 1'b1; a_data = 32'd5; a_sel = 1'b1;
    b_valid = 1'b1; b_data = 32'd3;
    tick();
    check("lat_n_out_valid", 64'(out_valid), 64'(0));
    check("lat_n_count", 64'(count), 64'(0));
    tick();
    check("lat_n1_out_valid", 64'(out_valid), 64'(1));
    check("lat_n1_opa", 64'(opa), 64'(5));
    check("lat_n1_opb", 64'(opb), 64'(3));
    check("lat_n1_sel", 64'(sel), 64'(1));
    check("lat_n1_count", 64'(count), 64'(1));
    tick();
    check("lat_n2_count", 64'(count), 64'(0));
    check("lat_n2_out_valid", 64'(out_valid), 64'(0));

    // A runs ahead by one; second A must stall until B catches up
    a_valid = 1'b1; a_data = 32'd7; a_sel = 1'b0;
    tick();
    a_valid = 1'b1; a_data = 32'd9; a_sel = 1'b1;
    #1;
    check("ahead_a_ready_low", 64'(a_ready), 64'(0));
    @(negedge clk);
    tick();
    check("ahead_a_held", 64'(a_valid), 64'(1));
    b_valid = 1'b1; b_data = 32'd2;
    tick();
    b_valid = 1'b1; b_data = 32'd4;
    n = 0;
    while ((a_valid || b_valid) && n < 20) begin
      tick();
      n++;
    end
    check("ahead_accepted", 64'(a_valid || b_valid), 64'(0));
    drain();

    // Fill to DEPTH with a fifth pair parked in the slots
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send_pair(32'h100 + 32'(k), k[0], 32'h200 + 32'(k));
    end
    tick();
    tick();
    check("full_count", 64'(count), 64'(4));
    check("full_a_ready", 64'(a_ready), 64'(0));
    check("full_b_ready", 64'(b_ready), 64'(0));
    check("full_opa", 64'(opa), 64'(32'h100));

    // One pop frees a slot for the parked pair on the same edge
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("wrap_count_kept", 64'(count), 64'(4));
    check("wrap_a_ready", 64'(a_ready), 64'(1));
    check("wrap_opa_next", 64'(opa), 64'(32'h101));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_pair(32'h300 + 32'(k), 1'b1, 32'h400 + 32'(k));
    end
    drain();

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    send_pair(32'h51, 1'b0, 32'h61);
    send_pair(32'h52, 1'b1, 32'h62);
    a_valid = 1'b1; a_data = 32'h53; a_sel = 1'b1;
    tick();
    tick();
    check("pre_rst_count", 64'(count), 64'(2));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_count", 64'(count), 64'(0));
    check("mid_rst_a_ready", 64'(a_ready), 64'(1));
    check("mid_rst_b_ready", 64'(b_ready), 64'(1));
    #1;
    rst = 1'b0;
    a_q.delete(); b_q.delete(); exp_q.delete();
    @(negedge clk);
    out_ready = 1'b1;
    b_valid = 1'b1; b_data = 32'd1;
    repeat (5) tick();
    check("post_rst_no_issue", 64'(out_valid), 64'(0));
    check("post_rst_count", 64'(count), 64'(0));
    a_valid = 1'b1; a_data = 32'h77; a_sel = 1'b0;
    tick();
    drain();

    // Random valid/ready traffic
    n_recv = 0;
    begin
      int sent_a;
      int sent_b;
      int cyc;
      sent_a = 0; sent_b = 0; cyc = 0;
      while (n_recv < NPAIR && cyc < 60000) begin
        if (!a_valid && sent_a < NPAIR && $urandom_range(0, 9) < 7) begin
          a_valid = 1'b1; a_data = $urandom; a_sel = 1'($urandom_range(0, 1));
          sent_a++;
        end
        if (!b_valid && sent_b < NPAIR && $urandom_range(0, 9) < 7) begin
          b_valid = 1'b1; b_data = $urandom;
          sent_b++;
        end
        out_ready = ($urandom_range(0, 9) < 7);
        tick();
        cyc++;
      end
    end
    check("random_received", 64'(n_recv), 64'(NPAIR));
    check("random_queue_empty", 64'(exp_q.size()), 64'(0));
    check("random_final_count", 64'(count), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
